fetch_stage: RTL and testbench



---
 rtl/rv_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_fifo_chk.sv | 22 ++
 rtl/fetch_stage_chk.sv | 17 +
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 266 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/rv_pkg.sv
// Shared types for the front end: NOP encoding, fetch FSM states and the
// {pc, insn} entry handed from fetch to decode.
package rv_pkg;

  localparam int PC_W   = 32;
  localparam int INSN_W = 32;

  localparam logic [INSN_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  T               mem_r [DEPTH];
  logic [AW:0]    wptr_r;
  logic [AW:0]    rptr_r;

  // Pointer update; flush takes priority over push and pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push) wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      if (pop)  rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_r[wptr_r[AW-1:0]] <= push_data;
  end

  assign head  = mem_r[rptr_r[AW-1:0]];
  assign count = wptr_r - rptr_r;

  fetch_fifo_chk #(.DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .count (count)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Protocol checks for fetch_fifo: no push into a full FIFO, no pop from an
// empty one (flush cycles excepted).
module fetch_fifo_chk #(
  parameter int DEPTH = 4
)(
  input logic                     clk,
  input logic                     rst,
  input logic                     flush,
  input logic                     push,
  input logic                     pop,
  input logic [$clog2(DEPTH):0]   count
);

  push_not_full_a: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && (count == ($clog2(DEPTH)+1)'(DEPTH))))
    else $error("fetch_fifo: push into full FIFO");

  pop_not_empty_a: assert property (@(posedge clk) disable iff (rst)
    !(pop && !flush && (count == {($clog2(DEPTH)+1){1'b0}})))
    else $error("fetch_fifo: pop from empty FIFO");

endmodule

// File: rtl/fetch_stage_chk.sv
// Invariant for fetch_stage: outside a flush, every in-flight request has
// its PC waiting in the request-PC queue.
module fetch_stage_chk #(
  parameter int CW = 3
)(
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] drop_cnt,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] pcq_count
);

  pcq_tracks_outstanding_a: assert property (@(posedge clk) disable iff (rst)
    (drop_cnt != {CW{1'b0}}) || (pcq_count == outstanding))
    else $error("fetch_stage: PC queue out of step with outstanding requests");

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues word requests, buffers in-order
// responses and hands {pc, insn} to decode; redirect flushes everything.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int                AWIDTH     = 32,
  parameter int                DWIDTH     = 32,
  parameter logic [AWIDTH-1:0] RESET_PC   = 32'h0100_0000,
  parameter int                FIFO_DEPTH = 4
)(
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_r, next_state_s;
  logic [AWIDTH-1:0] fetch_pc_r;
  logic [CW-1:0]     outstanding_r, outstanding_next_s;
  logic [CW-1:0]     drop_cnt_r, drop_next_s, redirect_drop_s;
  logic [CW-1:0]     buf_count_s, pcq_count_s;
  logic [CW:0]       occupancy_s;
  logic              req_fire_s, rsp_keep_s, rsp_drop_s, pop_s;
  logic [AWIDTH-1:0] pcq_head_s;
  fetch_entry_t      push_entry_s, head_entry_s;

  // Credit check uses registered counts only: a pop this cycle frees no slot yet.
  assign occupancy_s      = {1'b0, outstanding_r} + {1'b0, buf_count_s};
  assign imem_req_valid_o = (state_r == RUN) && !redirect_i &&
                            (occupancy_s < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o      = fetch_pc_r;
  assign req_fire_s       = imem_req_valid_o && imem_req_ready_i;
  assign rsp_keep_s       = imem_rsp_valid_i && !redirect_i && (drop_cnt_r == {CW{1'b0}});
  assign rsp_drop_s       = imem_rsp_valid_i && !redirect_i && (drop_cnt_r != {CW{1'b0}});
  assign redirect_drop_s  = outstanding_r - {{(CW-1){1'b0}}, imem_rsp_valid_i};

  assign valid_o      = (buf_count_s != {CW{1'b0}}) && !redirect_i;
  assign pop_s        = valid_o && ready_i;
  assign pc_o         = valid_o ? head_entry_s.pc : {AWIDTH{1'b0}};
  assign insn_o       = valid_o ? head_entry_s.insn : NOP;
  assign push_entry_s = '{pc: pcq_head_s, insn: imem_rsp_data_i};

  // In-flight and drop counters; a response arriving with a redirect is dropped.
  always_comb begin
    outstanding_next_s = outstanding_r;
    drop_next_s        = drop_cnt_r;
    if (redirect_i) begin
      outstanding_next_s = redirect_drop_s;
      drop_next_s        = redirect_drop_s;
    end else begin
      outstanding_next_s = outstanding_r + {{(CW-1){1'b0}}, req_fire_s}
                                         - {{(CW-1){1'b0}}, imem_rsp_valid_i};
      if (rsp_drop_s) begin
        drop_next_s = drop_cnt_r - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        drop_next_s = drop_cnt_r;
      end
    end
  end

  // Next-state logic; redirect overrides the normal transitions.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:  next_state_s = RUN;
      RUN:   next_state_s = RUN;
      FLUSH: next_state_s = (drop_next_s == {CW{1'b0}}) ? RUN : FLUSH;
      default: next_state_s = IDLE;
    endcase
    if (redirect_i) begin
      next_state_s = (redirect_drop_s == {CW{1'b0}}) ? RUN : FLUSH;
    end else begin
      next_state_s = next_state_s;
    end
  end

  // State, PC and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
    end else begin
      state_r       <= next_state_s;
      outstanding_r <= outstanding_next_s;
      drop_cnt_r    <= drop_next_s;
      if (redirect_i) begin
        fetch_pc_r <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
      end else if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + AWIDTH'(4);
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [AWIDTH-1:0])) u_pc_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_i),
    .push      (req_fire_s),
    .push_data (fetch_pc_r),
    .pop       (rsp_keep_s),
    .head      (pcq_head_s),
    .count     (pcq_count_s)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_i),
    .push      (rsp_keep_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_entry_s),
    .count     (buf_count_s)
  );

  fetch_stage_chk #(.CW(CW)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .drop_cnt    (drop_cnt_r),
    .outstanding (outstanding_r),
    .pcq_count   (pcq_count_s)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory model with configurable
// latency, a per-cycle vector table after reset, and flush/reset sequences.
module tb_fetch_stage;
  import rv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0100_0000;

  logic        clk, rst;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o, ready_i;
  logic [31:0] pc_o, insn_o;

  fetch_stage #(.AWIDTH(32), .DWIDTH(32), .RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o(imem_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .insn_o(insn_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic        rst;
    logic        exp_valid;
    logic        exp_req;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  mreq_t       mq[$];
  vec_t        vecs[7];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, lat = 1, mode = 0, last_due = 0, n_req = 0, n_pop = 0, p0;
  logic        rand_lat = 1'b0;
  logic [31:0] exp_pc = RST_PC;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a ^ 32'h5EED_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  // Memory response and ready for the current cycle, then let outputs settle.
  task automatic sample();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = insn_of(mq[0].addr);
    end
    case (mode)
      0: imem_req_ready_i = 1'b1;
      1: imem_req_ready_i = 1'($urandom_range(0, 1));
      default: imem_req_ready_i = 1'b0;
    endcase
    #1;
  endtask

  // Record handshakes, check every instruction taken by decode, advance a cycle.
  task automatic tick();
    int d;
    if (!rst) begin
      if (imem_rsp_valid_i) void'(mq.pop_front());
      if (imem_req_valid_o && imem_req_ready_i) begin
        d = cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat);
        if (d <= last_due) d = last_due + 1;
        mq.push_back('{addr: imem_addr_o, due: d});
        last_due = d;
        n_req++;
      end
      if (valid_o && ready_i) begin
        chk("stream_pc", pc_o, exp_pc);
        chk("stream_insn", insn_o, insn_of(exp_pc));
        exp_pc += 32'd4;
        n_pop++;
      end
    end else begin
      mq.delete();
      last_due = cyc;
      exp_pc   = RST_PC;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      tick();
    end
  endtask

  // No requests or outputs until the last stale response, then fetch resumes.
  task automatic wait_flush(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      sample();
      if (mq.size() > 0) begin
        chk({name, "_no_req"}, 32'(imem_req_valid_o), 32'd0);
        chk({name, "_no_valid"}, 32'(valid_o), 32'd0);
      end else begin
        chk({name, "_resume"}, 32'(imem_req_valid_o), 32'd1);
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      n_chk++;
      $display("FAIL %s_timeout: flush never ended", name);
    end
  endtask

  task automatic first_valid(input string name, input logic [31:0] want);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      sample();
      if (valid_o) begin
        chk(name, pc_o, want);
        seen = 1'b1;
      end
      tick();
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL %s_timeout: valid_o never rose", name);
    end
  endtask

  initial begin
    rst = 1'b1; ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_req_ready_i = 1'b1; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0;

    // Test 1: reset values and first fetches (1-cycle memory, decode always ready).
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0100_0000};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0100_0000};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0100_0000};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0100_0004};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0100_0000, 32'h0100_0008};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0100_0004, 32'h0100_000C};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0100_0008, 32'h0100_0010};
    @(negedge clk);
    run(2);
    for (int i = 0; i < 7; i++) begin
      rst = vecs[i].rst;
      sample();
      chk($sformatf("t1_valid_r%0d", i), 32'(valid_o), 32'(vecs[i].exp_valid));
      chk($sformatf("t1_req_r%0d", i), 32'(imem_req_valid_o), 32'(vecs[i].exp_req));
      chk($sformatf("t1_pc_r%0d", i), pc_o, vecs[i].exp_pc);
      chk($sformatf("t1_addr_r%0d", i), imem_addr_o, vecs[i].exp_addr);
      chk($sformatf("t1_insn_r%0d", i), insn_o,
          vecs[i].exp_valid ? insn_of(vecs[i].exp_pc) : NOP);
      tick();
    end

    // Test 2: decode stalls, buffer fills, requests stop, then drain in order.
    ready_i = 1'b0;
    run(10);
    sample();
    chk("t2_req_stopped", 32'(imem_req_valid_o), 32'd0);
    chk("t2_valid_held", 32'(valid_o), 32'd1);
    chk("t2_head_pc", pc_o, exp_pc);
    chk("t2_buffered", 32'(n_req - n_pop), 32'd4);
    tick();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk($sformatf("t2_drain_%0d", i), 32'(valid_o), 32'd1);
      tick();
    end
    run(4);

    // Test 3: redirect with exactly two requests in flight.
    mode = 2;
    run(6);
    lat = 4; mode = 0;
    run(2);
    mode = 2; redirect_i = 1'b1; redirect_pc_i = 32'h0100_0203;
    sample();
    chk("t3_inflight", 32'(mq.size()), 32'd2);
    chk("t3_req_masked", 32'(imem_req_valid_o), 32'd0);
    tick();
    redirect_i = 1'b0; exp_pc = 32'h0100_0200; mode = 0; lat = 1;
    sample();
    chk("t3_new_pc", imem_addr_o, 32'h0100_0200);
    wait_flush("t3");
    first_valid("t3_first_pc", 32'h0100_0200);
    run(4);

    // Test 4: redirect coinciding with a response and a would-be pop.
    lat = 2;
    run(8);
    redirect_i = 1'b1; redirect_pc_i = 32'h0100_0402;
    sample();
    chk("t4_rsp_now", 32'(imem_rsp_valid_i), 32'd1);
    chk("t4_inflight", 32'(mq.size()), 32'd2);
    chk("t4_valid_masked", 32'(valid_o), 32'd0);
    chk("t4_req_masked", 32'(imem_req_valid_o), 32'd0);
    tick();
    redirect_i = 1'b0; exp_pc = 32'h0100_0400; lat = 1;
    wait_flush("t4");
    first_valid("t4_first_pc", 32'h0100_0400);

    // Test 5: random memory ready, 1-3 cycle latency, random decode stalls.
    p0 = n_pop; mode = 1; rand_lat = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      sample();
      tick();
    end
    rand_lat = 1'b0; mode = 0; ready_i = 1'b1;
    run(8);
    chk("t5_progress", 32'(n_pop - p0 > 60), 32'd1);

    // Test 6: fill the buffer, enter FLUSH, then reset mid-operation.
    run(5);
    lat = 5; ready_i = 1'b0;
    run(14);
    sample();
    chk("t6_full_no_req", 32'(imem_req_valid_o), 32'd0);
    chk("t6_full_head", pc_o, exp_pc);
    tick();
    ready_i = 1'b1;
    run(1);
    ready_i = 1'b0;
    run(2);
    redirect_i = 1'b1; redirect_pc_i = 32'h0100_0808;
    sample();
    chk("t6_inflight", 32'(mq.size()), 32'd1);
    tick();
    redirect_i = 1'b0; exp_pc = 32'h0100_0808;
    sample();
    chk("t6_in_flush", 32'(imem_req_valid_o), 32'd0);
    tick();
    rst = 1'b1;
    sample();
    tick();
    rst = 1'b0; lat = 1; ready_i = 1'b1;
    sample();
    chk("t6_rst_valid", 32'(valid_o), 32'd0);
    chk("t6_rst_req", 32'(imem_req_valid_o), 32'd0);
    chk("t6_rst_pc", pc_o, 32'h0);
    chk("t6_rst_insn", insn_o, NOP);
    chk("t6_rst_addr", imem_addr_o, RST_PC);
    tick();
    first_valid("t6_restart_pc", RST_PC);
    run(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
